afe_cal_sequencer: RTL and testbench

Power-up and gain-calibration sequencer for the analog front end. After the serial configuration load completes, it runs the amplifier and core reset sequence and enables the ring oscillator. It then averages the 4-bit ADC output and steps the amplifier gain until the averaged code lands inside a target window. It sits beside the serial config block in `backend`, and its outputs drive the amplifier, core and RO control pins.

---
 rtl/afe_cal_sequencer_pkg.sv | 30 +++
 rtl/afe_cal_sequencer_if.sv | 28 ++
 rtl/afe_cal_sequencer_acc.sv | 63 ++++++
 rtl/afe_cal_sequencer.sv | 170 +++++++++++++++++
 tb/tb_afe_cal_sequencer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/afe_cal_sequencer_pkg.sv
// Shared types and constants for the AFE power-up / gain-calibration sequencer.
package afe_cal_pkg;

  localparam int unsigned GAIN_W = 3;
  localparam int unsigned ADC_W  = 4;

  localparam int unsigned AMP_RST_CYC_DEF = 8;
  localparam int unsigned SETTLE_CYC_DEF  = 16;
  localparam int unsigned AVG_LOG2_DEF    = 2;
  localparam int unsigned ADC_LO_DEF      = 4;
  localparam int unsigned ADC_HI_DEF      = 11;
  localparam int unsigned MAX_ITER_DEF    = 8;
  localparam int unsigned GAIN_INIT_DEF   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AMP_RST,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_DONE
  } cal_state_e;

  // One gain step towards the target window; callers guarantee no wrap.
  function automatic logic [GAIN_W-1:0] gain_step(input logic [GAIN_W-1:0] g,
                                                  input logic up);
    return up ? (g + GAIN_W'(1)) : (g - GAIN_W'(1));
  endfunction

endpackage

// File: rtl/afe_cal_sequencer_if.sv
// Control/status bundle between the calibration sequencer and its surroundings.
interface afe_cal_sequencer_if;
  import afe_cal_pkg::*;

  logic              i_start;
  logic [ADC_W-1:0]  i_ADCout;
  logic              o_resetb_amp;
  logic              o_resetb_core;
  logic              o_enableRO;
  logic [GAIN_W-1:0] o_gain;
  logic              o_busy;
  logic              o_done;
  logic              o_cal_fail;
  logic [ADC_W-1:0]  o_adc_avg;

  modport master (
    output i_start, i_ADCout,
    input  o_resetb_amp, o_resetb_core, o_enableRO, o_gain,
           o_busy, o_done, o_cal_fail, o_adc_avg
  );

  modport slave (
    input  i_start, i_ADCout,
    output o_resetb_amp, o_resetb_core, o_enableRO, o_gain,
           o_busy, o_done, o_cal_fail, o_adc_avg
  );

endinterface

// File: rtl/afe_cal_sequencer_acc.sv
// ADC sample accumulator: clears, sums 2^AVG_LOG2 samples, flags completion
// and presents the truncated average.
module adc_avg_acc
  import afe_cal_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [ADC_W-1:0] sample_i,
  output logic             last_o,
  output logic             done_o,
  output logic [ADC_W-1:0] avg_o
);

  localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam int unsigned NSAMP = 1 << AVG_LOG2;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             take;

  // Next-state for accumulator, sample count and completion flag.
  always_comb begin
    take   = en_i && !done_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clr_i) begin
      acc_d  = '0;
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (take) begin
      acc_d = acc_q + ACC_W'(sample_i);
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(NSAMP - 1)) done_d = 1'b1;
    end
  end

  // Accumulator state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // last_o marks the cycle whose sample completes the set, so the FSM can
  // leave SAMPLE on the same edge that captures it.
  assign last_o = take && (cnt_q == CNT_W'(NSAMP - 1));
  assign done_o = done_q;
  assign avg_o  = acc_q[AVG_LOG2 +: ADC_W];

endmodule

// File: rtl/afe_cal_sequencer.sv
// AFE power-up and gain-calibration sequencer: resets amplifier/core, enables
// the ring oscillator, averages the ADC and steps gain into a target window.
module afe_cal_sequencer
  import afe_cal_pkg::*;
#(
  parameter int unsigned AMP_RST_CYC = AMP_RST_CYC_DEF,
  parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int unsigned AVG_LOG2    = AVG_LOG2_DEF,
  parameter int unsigned ADC_LO      = ADC_LO_DEF,
  parameter int unsigned ADC_HI      = ADC_HI_DEF,
  parameter int unsigned MAX_ITER    = MAX_ITER_DEF,
  parameter int unsigned GAIN_INIT   = GAIN_INIT_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_resetbAll,
  afe_cal_sequencer_if.slave   bus
);

  localparam int unsigned CYC_MAX = (AMP_RST_CYC > SETTLE_CYC) ? AMP_RST_CYC : SETTLE_CYC;
  localparam int unsigned CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int unsigned ITER_W  = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;

  cal_state_e        state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic              fail_q, fail_d;
  logic [ADC_W-1:0]  avg_q, avg_d;
  logic              amp_q, amp_d;
  logic              core_q, core_d;
  logic              ro_q, ro_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              acc_last;
  logic              acc_done;
  logic [ADC_W-1:0]  acc_avg;
  logic              avg_low, avg_high;

  adc_avg_acc #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_acc (
    .clk_i    (i_clk),
    .rst_ni   (i_resetbAll),
    .clr_i    (state_q == ST_SETTLE),
    .en_i     (state_q == ST_SAMPLE),
    .sample_i (bus.i_ADCout),
    .last_o   (acc_last),
    .done_o   (acc_done),
    .avg_o    (acc_avg)
  );

  assign avg_low  = acc_avg < ADC_W'(ADC_LO);
  assign avg_high = acc_avg > ADC_W'(ADC_HI);

  // Next-state, counters, gain and result decode.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    iter_d  = iter_q;
    gain_d  = gain_q;
    fail_d  = fail_q;
    avg_d   = avg_q;
    unique case (state_q)
      ST_IDLE: begin
        gain_d = GAIN_W'(GAIN_INIT);
        if (bus.i_start) begin
          state_d = ST_AMP_RST;
          cyc_d   = '0;
          iter_d  = '0;
          fail_d  = 1'b0;
        end
      end
      ST_AMP_RST: begin
        if (cyc_q == CYC_W'(AMP_RST_CYC - 1)) begin
          state_d = ST_SETTLE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cyc_q == CYC_W'(SETTLE_CYC - 1)) begin
          state_d = ST_SAMPLE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (acc_last) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (acc_done) begin
          avg_d   = acc_avg;
          state_d = ST_DONE;
          if (!avg_low && !avg_high) begin
            fail_d = 1'b0;
          end else if ((avg_low && gain_q == '1) || (avg_high && gain_q == '0)) begin
            fail_d = 1'b1;
          end else if (iter_q == ITER_W'(MAX_ITER - 1)) begin
            fail_d = 1'b1;
          end else begin
            gain_d  = gain_step(gain_q, avg_low);
            iter_d  = iter_q + ITER_W'(1);
            cyc_d   = '0;
            state_d = ST_AMP_RST;
          end
        end
      end
      ST_DONE: begin
        if (bus.i_start) begin
          state_d = ST_AMP_RST;
          cyc_d   = '0;
          iter_d  = '0;
          gain_d  = GAIN_W'(GAIN_INIT);
          fail_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin levels are decoded from the next state so they are registered yet
    // already reflect the state entered on the same edge.
    amp_d  = state_d inside {ST_SETTLE, ST_SAMPLE, ST_EVAL, ST_DONE};
    core_d = state_d != ST_IDLE;
    ro_d   = amp_d;
    busy_d = state_d inside {ST_AMP_RST, ST_SETTLE, ST_SAMPLE, ST_EVAL};
    done_d = state_d == ST_DONE;
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      iter_q  <= '0;
      gain_q  <= GAIN_W'(GAIN_INIT);
      fail_q  <= 1'b0;
      avg_q   <= '0;
      amp_q   <= 1'b0;
      core_q  <= 1'b0;
      ro_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      iter_q  <= iter_d;
      gain_q  <= gain_d;
      fail_q  <= fail_d;
      avg_q   <= avg_d;
      amp_q   <= amp_d;
      core_q  <= core_d;
      ro_q    <= ro_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_resetb_amp  = amp_q;
  assign bus.o_resetb_core = core_q;
  assign bus.o_enableRO    = ro_q;
  assign bus.o_gain        = gain_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_cal_fail    = fail_q;
  assign bus.o_adc_avg     = avg_q;

endmodule

// File: tb/tb_afe_cal_sequencer.sv
// Self-checking bench for afe_cal_sequencer: default instance plus a
// MAX_ITER=2 instance, compared against a per-iteration reference model.
module tb_afe_cal_sequencer;

  localparam int ITER_LEN = 29;

  typedef struct packed {
    logic       amp;
    logic       core;
    logic       ro;
    logic [2:0] gain;
    logic       busy;
    logic       done;
    logic       fail;
    logic [3:0] avg;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [3:0] samp [8][4];
  int exp_g [8];
  int exp_a [8];

  afe_cal_sequencer_if b0 ();
  afe_cal_sequencer_if b1 ();

  afe_cal_sequencer u_dut (
    .i_clk       (clk),
    .i_resetbAll (rst_n),
    .bus         (b0)
  );

  afe_cal_sequencer #(
    .MAX_ITER (2)
  ) u_dut2 (
    .i_clk       (clk),
    .i_resetbAll (rst_n),
    .bus         (b1)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic obs_t get_obs(input bit use2);
    obs_t o;
    if (use2) o = {b1.o_resetb_amp, b1.o_resetb_core, b1.o_enableRO, b1.o_gain,
                   b1.o_busy, b1.o_done, b1.o_cal_fail, b1.o_adc_avg};
    else      o = {b0.o_resetb_amp, b0.o_resetb_core, b0.o_enableRO, b0.o_gain,
                   b0.o_busy, b0.o_done, b0.o_cal_fail, b0.o_adc_avg};
    return o;
  endfunction

  // ADC value for the cycle ending at start_edge + t: planned sample during
  // the SAMPLE window of each iteration, random junk otherwise.
  function automatic logic [3:0] adc_for(input int t);
    logic [3:0] v;
    v = 4'($urandom_range(15, 0));
    if (t >= 25) begin
      int k = (t - 25) % ITER_LEN;
      int i = (t - 25) / ITER_LEN;
      if (k < 4 && i < 8) v = samp[i][k];
    end
    return v;
  endfunction

  task automatic drive(input bit use2, input logic st, input logic [3:0] adc);
    b0.i_start  = st && !use2;
    b1.i_start  = st && use2;
    b0.i_ADCout = adc;
    b1.i_ADCout = adc;
  endtask

  task automatic fill_const(input logic [3:0] v);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++) samp[i][j] = v;
  endtask

  task automatic fill_alt(input logic [3:0] a, input logic [3:0] b);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++) samp[i][j] = (j % 2 == 0) ? a : b;
  endtask

  // Full calibration run from IDLE or DONE, checked against the model.
  task automatic run_cal(input string name, input bit use2, input int max_iter,
                         input int ign_t);
    int   g, n, sum, a, lim;
    bit   fail;
    obs_t o;

    // Reference model: one evaluation per iteration, plain arithmetic.
    g = 3; n = 0; fail = 1'b0; a = 0;
    for (int i = 0; i < max_iter; i++) begin
      exp_g[i] = g;
      sum = 0;
      for (int j = 0; j < 4; j++) sum += int'(samp[i][j]);
      a = sum / 4;
      exp_a[i] = a;
      n = i + 1;
      if (a >= 4 && a <= 11) begin fail = 1'b0; break; end
      if ((a < 4 && g == 7) || (a > 11 && g == 0) || i == max_iter - 1) begin
        fail = 1'b1; break;
      end
      g = (a < 4) ? g + 1 : g - 1;
    end
    lim = ITER_LEN * n;

    @(negedge clk); drive(use2, 1'b1, 4'($urandom_range(15, 0)));
    @(posedge clk); #1;
    o = get_obs(use2);
    checks++;
    if (o.busy !== 1'b1 || o.done !== 1'b0 || o.gain !== 3'd3 || o.amp !== 1'b0 ||
        o.core !== 1'b1 || o.ro !== 1'b0) begin
      errors++;
      $display("FAIL %s start: got amp=%b core=%b ro=%b gain=%0d busy=%b done=%b, required 0 1 0 3 1 0",
               name, o.amp, o.core, o.ro, o.gain, o.busy, o.done);
    end

    for (int t = 1; t <= lim; t++) begin
      @(negedge clk); drive(use2, (t == ign_t), adc_for(t));
      @(posedge clk); #1;
      o = get_obs(use2);
      if (t % ITER_LEN == 1) begin
        checks++;
        if (o.gain !== 3'(exp_g[t / ITER_LEN]) || o.busy !== 1'b1) begin
          errors++;
          $display("FAIL %s iter%0d_gain: got gain=%0d busy=%b, required gain=%0d busy=1",
                   name, t / ITER_LEN, o.gain, o.busy, exp_g[t / ITER_LEN]);
        end
      end
      if (t % ITER_LEN == 7 || t % ITER_LEN == 8) begin
        checks++;
        if (o.amp !== (t % ITER_LEN == 8) || o.ro !== (t % ITER_LEN == 8)) begin
          errors++;
          $display("FAIL %s amp_edge t=%0d: got amp=%b ro=%b, required %b",
                   name, t, o.amp, o.ro, (t % ITER_LEN == 8));
        end
      end
      if (t % ITER_LEN == 0) begin
        checks++;
        if (o.avg !== 4'(exp_a[t / ITER_LEN - 1])) begin
          errors++;
          $display("FAIL %s avg_iter%0d: got %0d, required %0d",
                   name, t / ITER_LEN - 1, o.avg, exp_a[t / ITER_LEN - 1]);
        end
      end
      if (t == lim - 1) begin
        checks++;
        if (o.done !== 1'b0 || o.busy !== 1'b1) begin
          errors++;
          $display("FAIL %s pre_done: got done=%b busy=%b, required 0 1", name, o.done, o.busy);
        end
      end
    end

    o = get_obs(use2);
    checks++;
    if (o.done !== 1'b1 || o.busy !== 1'b0 || o.gain !== 3'(g) || o.fail !== fail ||
        o.avg !== 4'(a) || o.amp !== 1'b1 || o.core !== 1'b1 || o.ro !== 1'b1) begin
      errors++;
      $display("FAIL %s result: got done=%b busy=%b gain=%0d fail=%b avg=%0d pins=%b%b%b, required 1 0 %0d %b %0d 111",
               name, o.done, o.busy, o.gain, o.fail, o.avg, o.amp, o.core, o.ro, g, fail, a);
    end

    @(negedge clk); drive(use2, 1'b0, 4'($urandom_range(15, 0)));
    repeat (3) @(posedge clk);
    #1;
    o = get_obs(use2);
    checks++;
    if (o.done !== 1'b1 || o.gain !== 3'(g)) begin
      errors++;
      $display("FAIL %s done_hold: got done=%b gain=%0d, required 1 %0d", name, o.done, o.gain, g);
    end
  endtask

  task automatic test_reset();
    obs_t o;
    drive(1'b0, 1'b0, 4'd0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      o = get_obs(k == 1);
      checks++;
      if (o !== obs_t'({1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd0})) begin
        errors++;
        $display("FAIL reset_values dut%0d: got %h, required %h", k, o,
                 obs_t'({1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd0}));
      end
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    o = get_obs(1'b0);
    checks++;
    if (o.busy !== 1'b0 || o.core !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: got busy=%b core=%b, required 0 0", o.busy, o.core);
    end
  endtask

  task automatic test_reset_mid_settle();
    obs_t o;
    @(negedge clk); drive(1'b0, 1'b1, 4'd8);
    @(posedge clk);
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk); drive(1'b0, 1'b0, 4'd8);
      @(posedge clk);
    end
    #2;
    o = get_obs(1'b0);
    checks++;
    if (o.amp !== 1'b1 || o.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_settle_pre: got amp=%b busy=%b, required 1 1", o.amp, o.busy);
    end
    rst_n = 1'b0;
    #1;
    o = get_obs(1'b0);
    checks++;
    if (o !== obs_t'({1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd0})) begin
      errors++;
      $display("FAIL async_reset: got %h, required %h", o,
               obs_t'({1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd0}));
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    o = get_obs(1'b0);
    checks++;
    if (o.busy !== 1'b0 || o.done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%b done=%b, required 0 0", o.busy, o.done);
    end
  endtask

  task automatic test_const();
    fill_const(4'd8);  run_cal("const8", 1'b0, 8, 0);
    fill_const(4'd1);  run_cal("const1", 1'b0, 8, 0);
    fill_const(4'd15); run_cal("const15_restart", 1'b0, 8, 0);
  endtask

  task automatic test_alternating();
    fill_alt(4'd3, 4'd5); run_cal("alt35", 1'b0, 8, 0);
    fill_alt(4'd3, 4'd4); run_cal("alt34", 1'b0, 8, 0);
  endtask

  task automatic test_start_ignored();
    fill_const(4'd13); run_cal("start_busy", 1'b0, 8, 40);
  endtask

  task automatic test_max_iter();
    fill_const(4'd1); run_cal("max_iter2", 1'b1, 2, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 4; j++) samp[i][j] = 4'($urandom_range(15, 0));
      run_cal($sformatf("rand%0d", r), (r % 3 == 2), (r % 3 == 2) ? 2 : 8, 0);
    end
  endtask

  initial begin
    test_reset();
    test_const();
    test_alternating();
    test_start_ignored();
    test_max_iter();
    test_random();
    test_reset_mid_settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
